// File: rtl/itype_encoder.sv
// RV32I I-type ALU instruction encoder feeding a small in-order output FIFO.
// Each popped instruction is tagged with a word address that advances from BASE_ADDR.
module itype_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op_sel,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rd,
    input  logic [11:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int           AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  CAP = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          run;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        shift;
    logic        illegal;
    logic [31:0] enc;
    logic        accept;
    logic        push;
    logic        pop;

    // Handshake: a request transfers on the edge where in_valid && in_ready;
    // an instruction leaves the head on the edge where out_valid && out_ready.
    always_comb begin
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        shift  = 1'b0;
        case (op_sel)
            3'd0:    funct3 = 3'b000;
            3'd1:    begin funct3 = 3'b001; shift = 1'b1; end
            3'd2:    funct3 = 3'b100;
            3'd3:    begin funct3 = 3'b101; shift = 1'b1; end
            3'd4:    begin funct3 = 3'b101; shift = 1'b1; funct7 = 7'b0100000; end
            3'd5:    funct3 = 3'b110;
            3'd6:    funct3 = 3'b111;
            default: funct3 = 3'b000;
        endcase
        illegal = (op_sel == 3'd7) || (shift && (imm[11:5] != 7'd0));
        enc     = {(shift ? {funct7, imm[4:0]} : imm), rs1, funct3, rd, 7'b0010011};
    end

    // run keeps in_ready low while reset is held and until the first clock edge after it.
    assign in_ready  = run && !flush && (count < CAP);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !illegal;
    assign pop       = out_valid && out_ready;
    assign instr     = out_valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run     <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            addr    <= BASE_ADDR;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            run <= 1'b1;
            err <= accept && illegal;
            if (accept && illegal && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                addr   <= BASE_ADDR;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    addr   <= addr + 32'd4;
                end
                case ({push, pop})
                    2'b10:   count <= count + (AW + 1)'(1);
                    2'b01:   count <= count - (AW + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
